// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter and sequencer for the external memory bus
module mem_port_arbiter #(
   parameter int AW          = 16,
   parameter int DW          = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          c,
   input  logic          r,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          done0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          winner;

   // On a tie the port that was not served last wins; otherwise the sole requester.
   assign winner = (req0 && req1) ? ~last_q : req1;
   assign rdata  = rdata_q;

   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d = winner;
               we_d    = winner ? we1 : we0;
               addr_d  = winner ? addr1 : addr0;
               wdata_d = winner ? wdata1 : wdata0;
               cnt_d   = CW'(WAIT_CYCLES);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            gnt0      = ~owner_q;
            gnt1      = owner_q;
            if (cnt_q == '0) begin
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            gnt0    = ~owner_q;
            gnt1    = owner_q;
            done0   = ~owner_q;
            done1   = owner_q;
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single 16-bit external memory bus that leaves the chip through the pad ring (address out, data out, data in).
- Port 0 is the CPU core; port 1 is the debug/boot loader.
- It grants one requester at a time using round-robin order.
- It drives the shared bus for a parameterised number of wait states, captures read data and returns a one-cycle done pulse.
- It sits between the core and the pad instances in the top-level pad wrapper.

Parameters:
AW, 16, address width
DW, 16, data width
WAIT_CYCLES, 2, extra cycles the bus is held after the first access cycle (0 allowed)

Ports:
c  input  1  clock, all state on rising edge
r  input  1  reset, asynchronous, active-low
req0  input  1  port 0 request
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
gnt0  output  1  port 0 owns the bus
done0  output  1  port 0 transaction complete, 1-cycle pulse
req1, we1, addr1, wdata1, gnt1, done1  same as port 0, for port 1
rdata  output  DW  read data for the completed transaction, shared by both ports
mem_en  output  1  bus access strobe
mem_we  output  1  bus write strobe
mem_addr  output  AW  bus address
mem_wdata  output  DW  bus write data
mem_rdata  input  DW  bus read data

Behaviour:
- Reset (r=0, asynchronous):
  - State goes to IDLE; the last-served pointer is set to 1, so port 0 wins the first tie.
  - All outputs are 0, including rdata, mem_addr and mem_wdata.
  - Any in-flight transaction is dropped; no done pulse is issued for it.
- State IDLE:
  - Bus outputs are 0 (mem_en, mem_we, mem_addr, mem_wdata).
  - If any req is high, choose a winner: the sole requester, or on a tie the port that was not last served.
  - Latch the winner's we/addr/wdata, set the wait counter to WAIT_CYCLES, and go to ACCESS.
- State ACCESS:
  - Hold mem_en=1; mem_we equals the latched we.
  - mem_addr and mem_wdata equal the latched values; they are stable for the whole access.
  - Leave when the counter reaches 0; otherwise decrement it.
  - ACCESS lasts exactly WAIT_CYCLES+1 cycles.
  - On the exit edge of a read, capture mem_rdata into rdata. On a write, rdata is left unchanged.
- State DONE:
  - Exactly one cycle; done of the granted port is 1; bus outputs return to 0.
  - Update the last-served pointer to the granted port; next state is IDLE.
- gnt of the granted port is high for the ACCESS and DONE cycles; never both gnt0 and gnt1 high at once.
- Latency:
  - A request sampled at edge k gives ACCESS from k+1 and done high in the cycle after edge k+WAIT_CYCLES+2.
  - rdata is valid from that cycle and holds until the next read completes.
- Request rules:
  - req is sampled only in IDLE; changes to req, addr, wdata or we after the grant are ignored.
  - A requester that keeps req high through done is treated as a new request in the next IDLE cycle.
  - The minimum gap between transactions is 1 IDLE cycle.
- Both ports requesting continuously strictly alternate: 0, 1, 0, 1, ...
- A req that drops during another port's transaction is lost; there is no queueing.
- Counter width is max(1, clog2(WAIT_CYCLES+1)). With WAIT_CYCLES=0 the access is a single cycle.

Test Plan:
- Single read, WAIT_CYCLES=2: req0=1, we0=0, addr0=16'h0010, mem_rdata=16'hBEEF -> mem_en high 3 cycles with mem_addr=0010; done0 high in the 4th cycle after the request edge; rdata=BEEF; gnt1 stays 0.
- Write: req1=1, we1=1, addr1=16'h1234, wdata1=16'hA5A5 -> mem_en=mem_we=1 for 3 cycles with stable addr/data; done1 pulse; rdata unchanged.
- Simultaneous first requests after reset: req0=req1=1 held -> grants alternate port 0, 1, 0, 1; each done pulse is on the matching port; exactly one IDLE cycle between accesses.
- Ignored mid-transaction change: change addr0 to 16'hFFFF during ACCESS -> mem_addr keeps the latched value.
- Reset mid-op: assert r=0 during the 2nd ACCESS cycle -> all outputs 0 immediately with no done. After release, a req1 alone is granted normally, and a subsequent tie goes to port 0.
- WAIT_CYCLES=0 build: read with mem_rdata=16'h0001 -> mem_en high 1 cycle; done0 in the 2nd cycle after the request edge; rdata=0001.
